// File: rtl/vmx_store_processor_pkg.sv
// Shared instruction field positions, FSM encoding and default widths for the VMX store drain.
// Pure declarations: no latency, no flow control.
package vmx_pkg;

  localparam int BASE_MSB = 31;
  localparam int BASE_LSB = 20;
  localparam int N_MSB    = 19;
  localparam int N_LSB    = 12;
  localparam int SH_MSB   = 11;
  localparam int SH_LSB   = 7;
  localparam int RELU_BIT = 0;

  localparam int BASE_W = BASE_MSB - BASE_LSB + 1;
  localparam int N_W    = N_MSB - N_LSB + 1;
  localparam int SH_W   = SH_MSB - SH_LSB + 1;

  localparam int DEF_ADDR_W = 12;
  localparam int DEF_LANES  = 4;
  localparam int DEF_ACC_W  = 32;
  localparam int DEF_OUT_W  = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_READ,
    S_CALC,
    S_WRITE,
    S_FIN
  } state_e;

endpackage

// File: rtl/vmx_store_processor_if.sv
// Store-FIFO, EAQ-FIFO and activation-memory write bus of the store drain.
// master = drain side (pops FIFOs, drives writes); slave = FIFO/memory side.
interface vmx_store_processor_if #(
  parameter int ADDR_W = 12,
  parameter int LANES  = 4,
  parameter int ACC_W  = 32,
  parameter int OUT_W  = 16
);
  logic [31:0]            ST_FIFO_DATA;
  logic                   ST_FIFO_EMPTY;
  logic                   ST_FIFO_RENA;
  logic [LANES*ACC_W-1:0] EAQ_FIFO_DATA;
  logic                   EAQ_FIFO_EMPTY;
  logic                   EAQ_FIFO_RENA;
  logic [ADDR_W-1:0]      MEM_WADDR;
  logic [LANES*OUT_W-1:0] MEM_WDATA;
  logic                   MEM_WENA;
  logic                   MEM_WREADY;

  modport master (
    input  ST_FIFO_DATA, ST_FIFO_EMPTY, EAQ_FIFO_DATA, EAQ_FIFO_EMPTY, MEM_WREADY,
    output ST_FIFO_RENA, EAQ_FIFO_RENA, MEM_WADDR, MEM_WDATA, MEM_WENA
  );

  modport slave (
    output ST_FIFO_DATA, ST_FIFO_EMPTY, EAQ_FIFO_DATA, EAQ_FIFO_EMPTY, MEM_WREADY,
    input  ST_FIFO_RENA, EAQ_FIFO_RENA, MEM_WADDR, MEM_WDATA, MEM_WENA
  );
endinterface

// File: rtl/vmx_store_processor_requant_lane.sv
// One-lane requantizer: arithmetic shift, optional ReLU, signed saturation to OUT_W.
// Purely combinational, zero latency, no flow control.
module vmx_requant_lane
  import vmx_pkg::*;
#(
  parameter int ACC_W = DEF_ACC_W,
  parameter int OUT_W = DEF_OUT_W
) (
  input  logic signed [ACC_W-1:0] acc_i,
  input  logic        [SH_W-1:0]  sh_i,
  input  logic                    relu_i,
  output logic signed [OUT_W-1:0] q_o
);

  localparam logic signed [ACC_W-1:0] MAX_V = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] MIN_V = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  logic signed [ACC_W-1:0] v;

  always_comb begin
    v = acc_i >>> sh_i;
    if (relu_i && (v < 0)) begin
      v = '0;
    end
    if (v > MAX_V) begin
      q_o = MAX_V[OUT_W-1:0];
    end else if (v < MIN_V) begin
      q_o = MIN_V[OUT_W-1:0];
    end else begin
      q_o = v[OUT_W-1:0];
    end
  end

endmodule

// File: rtl/vmx_store_processor.sv
// Drains EAQ result vectors, requantizes four lanes and writes packed words at BASE+idx.
// One write per 3 cycles best case; MEM_WREADY low holds the write, halt stalls pops only.
module vmx_store_processor
  import vmx_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int LANES  = DEF_LANES,
  parameter int ACC_W  = DEF_ACC_W,
  parameter int OUT_W  = DEF_OUT_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   sw_rst,
  input  logic                   halt,
  vmx_store_processor_if.master  bus,
  output logic                   BUSY,
  output logic                   DONE
);

  logic srst;
  assign srst = rst | sw_rst;

  state_e                 state_q, state_d;
  logic [BASE_W-1:0]      base_q, base_d;
  logic [N_W-1:0]         n_q, n_d;
  logic [SH_W-1:0]        sh_q, sh_d;
  logic                   relu_q, relu_d;
  logic [N_W-1:0]         idx_q, idx_d;
  logic [LANES*ACC_W-1:0] eaq_q, eaq_d;
  logic [ADDR_W-1:0]      waddr_q, waddr_d;
  logic [LANES*OUT_W-1:0] wdata_q, wdata_d;
  logic [LANES*OUT_W-1:0] lane_pack;
  logic                   st_rena, eaq_rena, wena;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    vmx_requant_lane #(
      .ACC_W (ACC_W),
      .OUT_W (OUT_W)
    ) u_lane (
      .acc_i  (eaq_q[g*ACC_W +: ACC_W]),
      .sh_i   (sh_q),
      .relu_i (relu_q),
      .q_o    (lane_pack[g*OUT_W +: OUT_W])
    );
  end

  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    n_d      = n_q;
    sh_d     = sh_q;
    relu_d   = relu_q;
    idx_d    = idx_q;
    eaq_d    = eaq_q;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;
    st_rena  = 1'b0;
    eaq_rena = 1'b0;
    wena     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!bus.ST_FIFO_EMPTY && !halt) begin
          st_rena = 1'b1;
          base_d  = bus.ST_FIFO_DATA[BASE_MSB:BASE_LSB];
          n_d     = bus.ST_FIFO_DATA[N_MSB:N_LSB];
          sh_d    = bus.ST_FIFO_DATA[SH_MSB:SH_LSB];
          relu_d  = bus.ST_FIFO_DATA[RELU_BIT];
          idx_d   = '0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        state_d = (n_q == '0) ? S_FIN : S_READ;
      end
      S_READ: begin
        if (!bus.EAQ_FIFO_EMPTY && !halt) begin
          eaq_rena = 1'b1;
          eaq_d    = bus.EAQ_FIFO_DATA;
          state_d  = S_CALC;
        end
      end
      S_CALC: begin
        wdata_d = lane_pack;
        waddr_d = ADDR_W'(base_q) + ADDR_W'(idx_q);
        state_d = S_WRITE;
      end
      S_WRITE: begin
        // halt is deliberately ignored here so an issued write is never withdrawn
        wena = 1'b1;
        if (bus.MEM_WREADY) begin
          idx_d   = idx_q + 1'b1;
          state_d = ({1'b0, idx_q} + 1'b1 < {1'b0, n_q}) ? S_READ : S_FIN;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      state_q <= S_IDLE;
      base_q  <= '0;
      n_q     <= '0;
      sh_q    <= '0;
      relu_q  <= 1'b0;
      idx_q   <= '0;
      eaq_q   <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      n_q     <= n_d;
      sh_q    <= sh_d;
      relu_q  <= relu_d;
      idx_q   <= idx_d;
      eaq_q   <= eaq_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

  // Strobes are masked during reset so a pending pop or write never lands on the reset edge
  assign bus.ST_FIFO_RENA  = st_rena & ~srst;
  assign bus.EAQ_FIFO_RENA = eaq_rena & ~srst;
  assign bus.MEM_WENA      = wena & ~srst;
  assign bus.MEM_WADDR     = waddr_q;
  assign bus.MEM_WDATA     = wdata_q;
  assign BUSY              = (state_q != S_IDLE);
  assign DONE              = (state_q == S_FIN);

endmodule

// File: tb/tb_vmx_store_processor.sv
// Directed bench for vmx_store_processor: FWFT FIFO models, write log, hand-computed expectations.
module tb_vmx_store_processor;

  logic clk = 1'b0;
  logic rst, sw_rst, halt;
  logic busy, done;

  always #5 clk = ~clk;

  vmx_store_processor_if #(.ADDR_W(12), .LANES(4), .ACC_W(32), .OUT_W(16)) sif ();

  vmx_store_processor #(.ADDR_W(12), .LANES(4), .ACC_W(32), .OUT_W(16)) dut (
    .clk    (clk),
    .rst    (rst),
    .sw_rst (sw_rst),
    .halt   (halt),
    .bus    (sif.master),
    .BUSY   (busy),
    .DONE   (done)
  );

  logic [31:0]  st_q[$];
  logic [127:0] eaq_q[$];
  logic [11:0]  wr_addr[$];
  logic [63:0]  wr_data[$];
  int st_pops, eaq_pops, done_cnt;
  int n_tests = 0;
  int n_fail = 0;
  bit pend_st = 0;
  bit pend_eaq = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mk_instr(input logic [11:0] base, input logic [7:0] n,
                                           input logic [4:0] sh, input logic relu);
    return {base, n, sh, 6'd0, relu};
  endfunction

  function automatic logic [127:0] mk_vec(input logic [31:0] l3, input logic [31:0] l2,
                                          input logic [31:0] l1, input logic [31:0] l0);
    return {l3, l2, l1, l0};
  endfunction

  // FIFO heads change only at negedge+1; strobes and writes are sampled at negedge+2.
  always @(negedge clk) begin
    #1;
    if (pend_st && st_q.size() > 0) void'(st_q.pop_front());
    if (pend_eaq && eaq_q.size() > 0) void'(eaq_q.pop_front());
    sif.ST_FIFO_EMPTY  = (st_q.size() == 0);
    sif.ST_FIFO_DATA   = (st_q.size() == 0) ? 32'd0 : st_q[0];
    sif.EAQ_FIFO_EMPTY = (eaq_q.size() == 0);
    sif.EAQ_FIFO_DATA  = (eaq_q.size() == 0) ? 128'd0 : eaq_q[0];
    #1;
    pend_st  = sif.ST_FIFO_RENA;
    pend_eaq = sif.EAQ_FIFO_RENA;
    if (pend_st) st_pops++;
    if (pend_eaq) eaq_pops++;
    if (sif.MEM_WENA && sif.MEM_WREADY) begin
      wr_addr.push_back(sif.MEM_WADDR);
      wr_data.push_back(sif.MEM_WDATA);
    end
    if (done) done_cnt++;
  end

  task automatic clear_logs();
    st_pops = 0;
    eaq_pops = 0;
    done_cnt = 0;
    wr_addr.delete();
    wr_data.delete();
  endtask

  task automatic step();
    @(negedge clk);
    #3;
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 300; i++) begin
      step();
      if (done_cnt != 0) break;
    end
    chk({tag, "_done_seen"}, 64'(done_cnt != 0), 64'd1);
    step();
  endtask

  task automatic wait_wena(input string tag);
    for (int i = 0; i < 100; i++) begin
      step();
      if (sif.MEM_WENA) break;
    end
    chk({tag, "_wena_seen"}, 64'(sif.MEM_WENA), 64'd1);
  endtask

  initial begin
    rst = 1'b1;
    sw_rst = 1'b0;
    halt = 1'b0;
    sif.MEM_WREADY = 1'b1;
    sif.ST_FIFO_EMPTY = 1'b1;
    sif.ST_FIFO_DATA = '0;
    sif.EAQ_FIFO_EMPTY = 1'b1;
    sif.EAQ_FIFO_DATA = '0;
    clear_logs();

    // Reset with a pending instruction: nothing may pop
    st_q.push_back(mk_instr(12'h010, 8'd2, 5'd0, 1'b0));
    repeat (3) step();
    chk("rst_st_rena", 64'(sif.ST_FIFO_RENA), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_wena", 64'(sif.MEM_WENA), 64'd0);
    chk("rst_waddr", 64'(sif.MEM_WADDR), 64'd0);
    chk("rst_wdata", sif.MEM_WDATA, 64'd0);
    chk("rst_st_pops", 64'(st_pops), 64'd0);

    // Basic store
    @(negedge clk);
    clear_logs();
    eaq_q.push_back(mk_vec(1, 2, 3, 4));
    eaq_q.push_back(mk_vec(5, 6, 7, 8));
    rst = 1'b0;
    wait_done("basic");
    repeat (3) step();
    chk("basic_nwr", 64'(wr_addr.size()), 64'd2);
    chk("basic_a0", 64'(wr_addr[0]), 64'h010);
    chk("basic_d0", wr_data[0], 64'h0001_0002_0003_0004);
    chk("basic_a1", 64'(wr_addr[1]), 64'h011);
    chk("basic_d1", wr_data[1], 64'h0005_0006_0007_0008);
    chk("basic_eaq_pops", 64'(eaq_pops), 64'd2);
    chk("basic_st_pops", 64'(st_pops), 64'd1);
    chk("basic_done_cnt", 64'(done_cnt), 64'd1);
    chk("basic_idle", 64'(busy), 64'd0);

    // Saturation, then shift with and without ReLU
    @(negedge clk);
    clear_logs();
    st_q.push_back(mk_instr(12'h020, 8'd1, 5'd0, 1'b0));
    eaq_q.push_back(mk_vec(40000, -40000, 32'h7FFF_FFFF, 0));
    wait_done("sat");
    chk("sat_d", wr_data[0], 64'h7FFF_8000_7FFF_0000);
    @(negedge clk);
    clear_logs();
    st_q.push_back(mk_instr(12'h030, 8'd1, 5'd4, 1'b1));
    st_q.push_back(mk_instr(12'h031, 8'd1, 5'd4, 1'b0));
    eaq_q.push_back(mk_vec(-8, 256, 3, -1));
    eaq_q.push_back(mk_vec(-8, 256, 3, -1));
    wait_done("relu1");
    wait_done("relu0");
    repeat (3) step();
    chk("shift_nwr", 64'(wr_addr.size()), 64'd2);
    chk("relu1_d", wr_data[0], 64'h0000_0010_0000_0000);
    chk("relu0_a", 64'(wr_addr[1]), 64'h031);
    chk("relu0_d", wr_data[1], 64'hFFFF_0010_0000_FFFF);

    // Write backpressure
    @(negedge clk);
    clear_logs();
    sif.MEM_WREADY = 1'b0;
    st_q.push_back(mk_instr(12'h040, 8'd2, 5'd0, 1'b0));
    eaq_q.push_back(mk_vec(100, 200, 300, 400));
    eaq_q.push_back(mk_vec(7, -7, 1000, -1000));
    wait_wena("bp");
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_wena_held", 64'(sif.MEM_WENA), 64'd1);
      chk("bp_waddr_held", 64'(sif.MEM_WADDR), 64'h040);
      chk("bp_wdata_held", sif.MEM_WDATA, 64'h0064_00C8_012C_0190);
      chk("bp_no_pop", 64'(eaq_pops), 64'd1);
    end
    @(negedge clk);
    sif.MEM_WREADY = 1'b1;
    step();
    chk("bp_accept", 64'(wr_addr.size()), 64'd1);
    wait_done("bp");
    chk("bp_a1", 64'(wr_addr[1]), 64'h041);
    chk("bp_d1", wr_data[1], 64'h0007_FFF9_03E8_FC18);

    // EAQ empty stall, then halt stall in READ
    @(negedge clk);
    clear_logs();
    st_q.push_back(mk_instr(12'h050, 8'd2, 5'd0, 1'b0));
    repeat (4) step();
    chk("stall_empty_pops", 64'(eaq_pops), 64'd0);
    chk("stall_busy", 64'(busy), 64'd1);
    @(negedge clk);
    halt = 1'b1;
    eaq_q.push_back(mk_vec(9, 10, 11, 12));
    eaq_q.push_back(mk_vec(-1, -2, -3, -4));
    repeat (5) step();
    chk("stall_halt_pops", 64'(eaq_pops), 64'd0);
    @(negedge clk);
    halt = 1'b0;
    wait_done("stall");
    chk("stall_a0", 64'(wr_addr[0]), 64'h050);
    chk("stall_d0", wr_data[0], 64'h0009_000A_000B_000C);
    chk("stall_a1", 64'(wr_addr[1]), 64'h051);
    chk("stall_d1", wr_data[1], 64'hFFFF_FFFE_FFFD_FFFC);

    // Address wrap
    @(negedge clk);
    clear_logs();
    st_q.push_back(mk_instr(12'hFFF, 8'd2, 5'd0, 1'b0));
    eaq_q.push_back(mk_vec(1, 1, 1, 1));
    eaq_q.push_back(mk_vec(2, 2, 2, 2));
    wait_done("wrap");
    chk("wrap_a0", 64'(wr_addr[0]), 64'hFFF);
    chk("wrap_a1", 64'(wr_addr[1]), 64'h000);
    chk("wrap_d1", wr_data[1], 64'h0002_0002_0002_0002);

    // N=0 with a waiting EAQ entry that must stay put
    @(negedge clk);
    clear_logs();
    eaq_q.push_back(mk_vec(3, 3, 3, 3));
    st_q.push_back(mk_instr(12'h070, 8'd0, 5'd0, 1'b0));
    wait_done("n0");
    repeat (2) step();
    chk("n0_eaq_pops", 64'(eaq_pops), 64'd0);
    chk("n0_nwr", 64'(wr_addr.size()), 64'd0);
    chk("n0_done_cnt", 64'(done_cnt), 64'd1);
    @(negedge clk);
    eaq_q.delete();

    // Software reset during WRITE
    @(negedge clk);
    clear_logs();
    sif.MEM_WREADY = 1'b0;
    st_q.push_back(mk_instr(12'h060, 8'd2, 5'd0, 1'b0));
    eaq_q.push_back(mk_vec(4, 4, 4, 4));
    eaq_q.push_back(mk_vec(5, 5, 5, 5));
    wait_wena("swrst");
    @(negedge clk);
    sw_rst = 1'b1;
    @(negedge clk);
    sw_rst = 1'b0;
    #3;
    chk("swrst_wena", 64'(sif.MEM_WENA), 64'd0);
    chk("swrst_busy", 64'(busy), 64'd0);
    chk("swrst_waddr", 64'(sif.MEM_WADDR), 64'd0);
    chk("swrst_nwr", 64'(wr_addr.size()), 64'd0);
    chk("swrst_eaq_pops", 64'(eaq_pops), 64'd1);
    @(negedge clk);
    sif.MEM_WREADY = 1'b1;
    eaq_q.delete();
    repeat (3) step();
    chk("swrst_stays_idle", 64'(busy), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
